receiver_i2c: RTL and testbench
===============================

# receiver_i2c

I2C target (slave) endpoint that answers the `transmitter_I2C` master on the same `clk` domain. Detects START/STOP and matches a 7-bit address. In write transactions it captures two data bytes into `RD_DATA`. In read transactions it returns `WR_DATA` MSB-first, handling ACK/NACK on the ninth clock of every byte.

## Interface
- `ADDR_W`, default 7: target address width.
- `DATA_W`, default 16: payload width; must be 2 bytes.
- `clk` in 1: system clock, same clock as the master.
- `rst` in 1: reset, asynchronous, active-low.
- `SCL` in 1: bus clock from the master.
- `SDA_IN` in 1: bus data as seen by the target.
- `I2C_ADDR` in 7: this target's own address.
- `WR_DATA` in 16: data returned to the master on a read.
- `SDA_OUT` out 1: data driven by the target; meaningful only while `SDA_OE`=1.
- `SDA_OE` out 1: target drives SDA when 1.
- `RD_DATA` out 16: last complete 2-byte write payload received.
- `DATA_VLD` out 1: one-cycle pulse when `RD_DATA` updates.
- `BUSY` out 1: high from START until STOP or end of transaction.

## Operation
- **Input conditioning:** `SCL` and `SDA_IN` each pass through a 2-flop synchronizer followed by a previous-value register. This yields `scl_rise`, `scl_fall`, `start_det` and `stop_det`.
  - `start_det`: SDA falls while SCL is high.
  - `stop_det`: SDA rises while SCL is high.
- **Bit handling:** data is sampled on `scl_rise`. SDA is changed only on `scl_fall`.
- **States:** IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
- **IDLE → ADDR** on `start_det`. `BUSY`=1 and the bit counter clears.
- **ADDR:** shift 8 bits, `{addr[6:0], RNW}`.
  - On the 8th rise with address match: go to ADDR_ACK. On the next `scl_fall`, `SDA_OE`=1 and `SDA_OUT`=0.
  - On mismatch: go to WAIT_STOP with `SDA_OE` held at 0.
- **ADDR_ACK:** on the `scl_fall` that ends the 9th bit, branch on RNW.
  - RNW=0: release SDA (`SDA_OE`=0) and go to WR_BYTE.
  - RNW=1: latch `WR_DATA` into the TX shift register and go to RD_BYTE. Drive bit 15 immediately; `SDA_OE` stays 1.
- **WR_BYTE / WR_ACK:**
  - Shift 8 bits per byte.
  - After the 8th rise, ACK the byte during the 9th bit (same SDA_OE/SDA_OUT timing as the address ACK).
  - After byte 2: `RD_DATA` ← `{byte1, byte2}` and `DATA_VLD` pulses.
  - A third byte is NACKed (SDA left released) → WAIT_STOP.
- **RD_BYTE / RD_ACK:**
  - Shift out MSB-first, one bit per `scl_fall`.
  - After the 8th bit's fall, `SDA_OE`=0 and the master's ACK is sampled on the 9th rise.
  - ACK after byte 1 → send byte 2.
  - ACK after byte 2 → wrap and resend `WR_DATA[15:8]` from the latched copy.
  - NACK → WAIT_STOP.
- **WAIT_STOP:** ignore bits until `stop_det` (→ IDLE) or `start_det` (→ ADDR).
- **Global overrides:**
  - `stop_det` in any state → IDLE, `SDA_OE`=0, `BUSY`=0.
  - `start_det` in any non-IDLE state → repeated start → ADDR.
  - Either event discards any partial write; `RD_DATA` is unchanged.
- **Write with one byte then STOP:** no `DATA_VLD` pulse, `RD_DATA` keeps its old value.

## Timing
- **Reset values:** `SDA_OUT`=1, `SDA_OE`=0, `RD_DATA`=0, `DATA_VLD`=0, `BUSY`=0, state IDLE. All are asserted immediately on `rst` low and released synchronously on the next `clk`.
- **Detection latency:** bus event → internal detect is 3 `clk` (2 sync flops + edge register).
- **SDA change latency:** `SDA_OUT`/`SDA_OE` update 1 `clk` after `scl_fall` detection, i.e. 4 `clk` after the bus SCL falling edge.
- **Bus timing requirement:** SCL high and low phases ≥ 4 `clk` each, so SDA is stable around every detected rise.
- **Write data latency:** `RD_DATA` and `DATA_VLD` are registered 1 `clk` after the 8th rise of byte 2. `DATA_VLD` is exactly 1 `clk` wide.
- **Read data capture:** `WR_DATA` is sampled once per transaction at the ADDR_ACK→RD_BYTE transition. Later changes do not affect the transfer in progress.
- **Reset mid-transaction:** SDA released immediately; no ACK leaks.

## Structure
- Package `i2c_pkg`:
  - state enum (3-bit);
  - `I2C_ADDR_W`=7 and `I2C_DATA_W`=16;
  - `I2C_ACK`=0 and `I2C_NACK`=1;
  - the byte length constant 8.
- Sub-module `i2c_line_sync` (instantiated once, carries both lines):
  - 2-flop synchronizer plus previous-value register for SCL and SDA;
  - outputs `scl_rise`, `scl_fall`, `start_det` and `stop_det`.
- Top level holds:
  - the FSM;
  - the 4-bit bit counter (0–8);
  - a 1-bit byte index;
  - 8-bit RX and 16-bit TX shift registers.

## Test plan
- **Addressed write:** `I2C_ADDR`=7'h2A; master writes addr 0x2A, RNW=0, data 0xBEEF, then STOP → three ACKs (SDA low on bit 9); `RD_DATA`=16'hBEEF; one `DATA_VLD` pulse; `BUSY` drops after STOP.
- **Address mismatch:** addr 0x15 with `I2C_ADDR`=0x2A → `SDA_OE` stays 0 for the entire transaction; `RD_DATA` unchanged; no `DATA_VLD`.
- **Read:** `WR_DATA`=16'hA55A; master reads 2 bytes, ACK then NACK → SDA bits 1010_0101 then 0101_1010; `SDA_OE`=0 during both master ACK slots; IDLE after STOP.
- **Read wrap and capture:** master ACKs a 3rd byte → 0xA5 is resent; `WR_DATA` changed to 0x1234 mid-read has no effect.
- **Partial write and repeated start:** write of 1 byte 0x12 then repeated START + write 0x3456 → `RD_DATA`=0x3456 with a single `DATA_VLD` pulse. A 3-byte write gets NACK on byte 3.
- **Reset mid-transaction:** `rst` low during the ACK bit → `SDA_OE`=0 in the same cycle; all outputs at reset values; after release, IDLE until the next START.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target endpoint.
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 16;
  localparam int I2C_BYTE_W = 8;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_WAIT_STOP
  } state_t;
endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA and produces registered edge, START and STOP pulses.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_sync,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);
  logic [1:0] scl_ff, sda_ff;
  logic       scl_q, sda_q;

  // Idle bus is high, so resetting to 1 avoids spurious edges after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_ff    <= 2'b11;
      sda_ff    <= 2'b11;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_ff    <= {scl_ff[0], scl};
      sda_ff    <= {sda_ff[0], sda};
      scl_q     <= scl_ff[1];
      sda_q     <= sda_ff[1];
      scl_rise  <= scl_ff[1] & ~scl_q;
      scl_fall  <= ~scl_ff[1] & scl_q;
      start_det <= scl_ff[1] & scl_q & sda_q & ~sda_ff[1];
      stop_det  <= scl_ff[1] & scl_q & ~sda_q & sda_ff[1];
    end
  end

  assign sda_sync = sda_q;
endmodule

// File: rtl/receiver_i2c.sv
// I2C target: 7-bit address match, 2-byte write capture, wrapping 2-byte read.
module receiver_i2c
  import i2c_pkg::*;
#(
  parameter int ADDR_W = I2C_ADDR_W,
  parameter int DATA_W = I2C_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCL,
  input  logic              SDA_IN,
  input  logic [ADDR_W-1:0] I2C_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              SDA_OUT,
  output logic              SDA_OE,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              DATA_VLD,
  output logic              BUSY
);
  localparam logic [3:0] LAST_BIT = 4'(I2C_BYTE_W - 1);
  localparam logic [3:0] ACK_BIT  = 4'(I2C_BYTE_W);

  state_t                  state, state_nxt;
  logic [3:0]              bit_cnt;
  logic                    byte_idx, wr_done, rnw;
  logic [I2C_BYTE_W-1:0]   rx_sr, byte1, rx_next;
  logic [DATA_W-1:0]       tx_sr;
  logic                    sda, scl_rise, scl_fall, start_det, stop_det;
  logic                    last_rise, ack_end, addr_hit;
  logic                    oe_nxt, out_nxt;

  i2c_line_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl      (SCL),
    .sda      (SDA_IN),
    .sda_sync (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  assign rx_next   = {rx_sr[I2C_BYTE_W-2:0], sda};
  assign last_rise = scl_rise && (bit_cnt == LAST_BIT);
  // In ack slots bit_cnt is 0 before the 9th rise and 1 after it.
  assign ack_end   = scl_fall && (bit_cnt == 4'd1);
  assign addr_hit  = (rx_sr[ADDR_W-1:0] == I2C_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop_det)       state_nxt = ST_IDLE;
    else if (start_det) state_nxt = ST_ADDR;
    else begin
      case (state)
        ST_ADDR:     if (last_rise) state_nxt = addr_hit ? ST_ADDR_ACK : ST_WAIT_STOP;
        ST_ADDR_ACK: if (ack_end)   state_nxt = rnw ? ST_RD_BYTE : ST_WR_BYTE;
        ST_WR_BYTE:  if (last_rise) state_nxt = wr_done ? ST_WAIT_STOP : ST_WR_ACK;
        ST_WR_ACK:   if (ack_end)   state_nxt = ST_WR_BYTE;
        ST_RD_BYTE:  if (scl_fall && bit_cnt == ACK_BIT) state_nxt = ST_RD_ACK;
        ST_RD_ACK: begin
          if (scl_rise && sda == I2C_NACK) state_nxt = ST_WAIT_STOP;
          else if (ack_end)                state_nxt = ST_RD_BYTE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    oe_nxt  = SDA_OE;
    out_nxt = SDA_OUT;
    if (stop_det || start_det) begin
      oe_nxt  = 1'b0;
      out_nxt = 1'b1;
    end else begin
      case (state)
        ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
          if (bit_cnt == 4'd0) begin
            oe_nxt  = 1'b1;
            out_nxt = I2C_ACK;
          end else if (state == ST_ADDR_ACK && rnw) begin
            oe_nxt  = 1'b1;
            out_nxt = WR_DATA[DATA_W-1];
          end else begin
            oe_nxt  = 1'b0;
            out_nxt = 1'b1;
          end
        end
        ST_RD_BYTE: if (scl_fall) begin
          if (bit_cnt == ACK_BIT) begin
            oe_nxt  = 1'b0;
            out_nxt = 1'b1;
          end else begin
            out_nxt = tx_sr[DATA_W-1];
          end
        end
        ST_RD_ACK: if (ack_end) begin
          oe_nxt  = 1'b1;
          out_nxt = tx_sr[DATA_W-1];
        end
        ST_IDLE, ST_WAIT_STOP: begin
          oe_nxt  = 1'b0;
          out_nxt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      SDA_OUT  <= 1'b1;
      SDA_OE   <= 1'b0;
      RD_DATA  <= '0;
      DATA_VLD <= 1'b0;
      BUSY     <= 1'b0;
      bit_cnt  <= '0;
      byte_idx <= 1'b0;
      wr_done  <= 1'b0;
      rnw      <= 1'b0;
      rx_sr    <= '0;
      byte1    <= '0;
      tx_sr    <= '0;
    end else begin
      SDA_OUT  <= out_nxt;
      SDA_OE   <= oe_nxt;
      BUSY     <= (state_nxt != ST_IDLE);
      DATA_VLD <= 1'b0;

      if (start_det || stop_det || state_nxt != state)
        bit_cnt <= '0;
      else if (scl_rise && state != ST_IDLE && state != ST_WAIT_STOP)
        bit_cnt <= bit_cnt + 4'd1;

      if (start_det || stop_det) begin
        byte_idx <= 1'b0;
        wr_done  <= 1'b0;
      end else begin
        if (scl_rise && (state == ST_ADDR || state == ST_WR_BYTE))
          rx_sr <= rx_next;
        if (state == ST_ADDR && last_rise)
          rnw <= sda;
        if (state == ST_WR_BYTE && last_rise && !wr_done) begin
          if (!byte_idx) begin
            byte1    <= rx_next;
            byte_idx <= 1'b1;
          end else begin
            RD_DATA  <= {byte1, rx_next};
            DATA_VLD <= 1'b1;
            wr_done  <= 1'b1;
            byte_idx <= 1'b0;
          end
        end
        // TX register rotates so that after 16 bits it points at the MSB again.
        if (state == ST_ADDR_ACK && ack_end && rnw)
          tx_sr <= {WR_DATA[DATA_W-2:0], WR_DATA[DATA_W-1]};
        else if ((state == ST_RD_BYTE && scl_fall && bit_cnt != ACK_BIT) ||
                 (state == ST_RD_ACK && ack_end))
          tx_sr <= {tx_sr[DATA_W-2:0], tx_sr[DATA_W-1]};
      end
    end
  end
endmodule

// File: tb/tb_receiver_i2c.sv
// Directed bench: bit-banged I2C master with open-drain bus model.
module tb_receiver_i2c;
  logic        clk = 1'b0;
  logic        rst, SCL, m_sda;
  logic [6:0]  I2C_ADDR;
  logic [15:0] WR_DATA;
  logic        SDA_OUT, SDA_OE, DATA_VLD, BUSY;
  logic [15:0] RD_DATA;
  logic        sda_bus;
  int          errors = 0, checks = 0;
  int          vld_cnt = 0, oe_cnt = 0;

  assign sda_bus = m_sda & (SDA_OE ? SDA_OUT : 1'b1);

  receiver_i2c dut (
    .clk     (clk),
    .rst     (rst),
    .SCL     (SCL),
    .SDA_IN  (sda_bus),
    .I2C_ADDR(I2C_ADDR),
    .WR_DATA (WR_DATA),
    .SDA_OUT (SDA_OUT),
    .SDA_OE  (SDA_OE),
    .RD_DATA (RD_DATA),
    .DATA_VLD(DATA_VLD),
    .BUSY    (BUSY)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (DATA_VLD) vld_cnt++;
    if (SDA_OE) oe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_xfer(input logic b, output logic seen, output logic oe_hi);
    tick(5); m_sda = b;
    tick(5); SCL = 1'b1;
    tick(4); seen = sda_bus; oe_hi = SDA_OE;
    tick(4); SCL = 1'b0;
  endtask

  task automatic start_c;
    m_sda = 1'b1; tick(5);
    SCL = 1'b1;   tick(5);
    m_sda = 1'b0; tick(5);
    SCL = 1'b0;
  endtask

  task automatic stop_c;
    tick(5); m_sda = 1'b0;
    tick(5); SCL = 1'b1;
    tick(5); m_sda = 1'b1;
    tick(10);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s, o;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s, o);
    bit_xfer(1'b1, ack, o);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d, output logic oe_ack);
    logic s, o;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s, o);
      d[i] = s;
    end
    bit_xfer(mack, s, oe_ack);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic       ack, o;
    logic [7:0] d;
    int         v0, o0;

    rst = 1'b0; SCL = 1'b1; m_sda = 1'b1;
    I2C_ADDR = 7'h2A; WR_DATA = 16'hA55A;
    tick(3);
    chk("rst_sda_out", SDA_OUT, 1);
    chk("rst_sda_oe", SDA_OE, 0);
    chk("rst_rd_data", RD_DATA, 0);
    chk("rst_vld", DATA_VLD, 0);
    chk("rst_busy", BUSY, 0);
    rst = 1'b1;
    tick(10);

    // addressed write 0xBEEF
    v0 = vld_cnt;
    start_c();
    wr_byte(8'h54, ack); chk("wr_addr_ack", ack, 0);
    chk("wr_busy", BUSY, 1);
    wr_byte(8'hBE, ack); chk("wr_b1_ack", ack, 0);
    wr_byte(8'hEF, ack); chk("wr_b2_ack", ack, 0);
    stop_c();
    chk("wr_rd_data", RD_DATA, 16'hBEEF);
    chk("wr_vld_pulses", vld_cnt - v0, 1);
    chk("wr_busy_after_stop", BUSY, 0);

    // address mismatch
    v0 = vld_cnt; o0 = oe_cnt;
    start_c();
    wr_byte(8'h2A, ack); chk("mis_addr_nack", ack, 1);
    wr_byte(8'h11, ack); chk("mis_data_nack", ack, 1);
    stop_c();
    chk("mis_oe_cycles", oe_cnt - o0, 0);
    chk("mis_rd_data", RD_DATA, 16'hBEEF);
    chk("mis_vld_pulses", vld_cnt - v0, 0);

    // read 2 bytes, ACK then NACK
    start_c();
    wr_byte(8'h55, ack); chk("rd_addr_ack", ack, 0);
    rd_byte(1'b0, d, o); chk("rd_b1", d, 8'hA5); chk("rd_b1_ack_oe", o, 0);
    rd_byte(1'b1, d, o); chk("rd_b2", d, 8'h5A); chk("rd_b2_ack_oe", o, 0);
    stop_c();
    chk("rd_busy_after_stop", BUSY, 0);
    chk("rd_oe_after_stop", SDA_OE, 0);

    // read wrap, WR_DATA change mid-read ignored
    start_c();
    wr_byte(8'h55, ack); chk("wrap_addr_ack", ack, 0);
    rd_byte(1'b0, d, o); chk("wrap_b1", d, 8'hA5);
    WR_DATA = 16'h1234;
    rd_byte(1'b0, d, o); chk("wrap_b2", d, 8'h5A);
    rd_byte(1'b1, d, o); chk("wrap_b3", d, 8'hA5);
    stop_c();

    // partial write then repeated start
    v0 = vld_cnt;
    start_c();
    wr_byte(8'h54, ack); chk("rs_addr1_ack", ack, 0);
    wr_byte(8'h12, ack); chk("rs_b1_ack", ack, 0);
    start_c();
    wr_byte(8'h54, ack); chk("rs_addr2_ack", ack, 0);
    wr_byte(8'h34, ack);
    wr_byte(8'h56, ack);
    stop_c();
    chk("rs_rd_data", RD_DATA, 16'h3456);
    chk("rs_vld_pulses", vld_cnt - v0, 1);

    // three-byte write: third byte NACKed
    v0 = vld_cnt;
    start_c();
    wr_byte(8'h54, ack);
    wr_byte(8'hAA, ack); chk("w3_b1_ack", ack, 0);
    wr_byte(8'hBB, ack); chk("w3_b2_ack", ack, 0);
    wr_byte(8'hCC, ack); chk("w3_b3_nack", ack, 1);
    stop_c();
    chk("w3_rd_data", RD_DATA, 16'hAABB);
    chk("w3_vld_pulses", vld_cnt - v0, 1);

    // one byte then STOP: no update
    v0 = vld_cnt;
    start_c();
    wr_byte(8'h54, ack);
    wr_byte(8'h77, ack);
    stop_c();
    chk("w1_rd_data", RD_DATA, 16'hAABB);
    chk("w1_vld_pulses", vld_cnt - v0, 0);

    // reset during the address ACK bit
    start_c();
    for (int i = 7; i >= 0; i--) bit_xfer(i[0] ? 1'b0 : (i == 6 || i == 4 || i == 2), ack, o);
    tick(5); m_sda = 1'b1; tick(1);
    chk("mid_ack_driven", SDA_OE, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_oe", SDA_OE, 0);
    chk("mid_rst_out", SDA_OUT, 1);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_rd_data", RD_DATA, 0);
    SCL = 1'b1; m_sda = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(20);
    chk("post_rst_busy", BUSY, 0);
    chk("post_rst_oe", SDA_OE, 0);
    start_c();
    wr_byte(8'h54, ack); chk("post_rst_addr_ack", ack, 0);
    wr_byte(8'h9A, ack);
    wr_byte(8'hBC, ack);
    stop_c();
    chk("post_rst_rd_data", RD_DATA, 16'h9ABC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
